// File: rtl/hex_bcd_display.sv
// Serial double-dabble binary-to-BCD converter driving six active-low 7-segment digits.
// Optional macro LEADING_ZERO_BLANK_EN blanks zero digits above the most significant nonzero digit.
module hex_bcd_display #(
  parameter bit AUTO_LOAD = 1'b0
) (
  input  logic        CLOCK_50,
  input  logic        Reset,
  input  logic [19:0] value,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5
);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  state_t      state_q, state_d;
  logic [19:0] bin_q, bin_d;
  logic [23:0] bcd_q, bcd_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [41:0] hex_q, hex_d;
  logic [23:0] adj;
  logic [41:0] seg_all;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // Add-3 correction applied to every nibble before the shift.
  always_comb begin
    adj = bcd_q;
    for (int j = 0; j < 6; j++) begin
      if (bcd_q[4*j +: 4] >= 4'd5) adj[4*j +: 4] = bcd_q[4*j +: 4] + 4'd3;
    end
  end

  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    logic lead;
    lead = 1'b1;
`endif
    seg_all = '1;
    for (int i = 5; i >= 0; i--) begin
      seg_all[7*i +: 7] = seg7(bcd_q[4*i +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
      if (lead && (bcd_q[4*i +: 4] == 4'd0) && (i != 0)) seg_all[7*i +: 7] = SEG_BLANK;
      else lead = 1'b0;
`endif
    end
    if (ovf_q) seg_all = {6{SEG_DASH}};
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    hex_d   = hex_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load || AUTO_LOAD) begin
          bin_d   = value;
          bcd_d   = '0;
          cnt_d   = '0;
          ovf_d   = (value > 20'd999999);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = (adj << 1) | {23'd0, bin_q[19]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd19) state_d = LATCH;
      end
      LATCH: begin
        hex_d   = seg_all;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hex_q   <= '1;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hex_q   <= hex_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign HEX0 = hex_q[6:0];
  assign HEX1 = hex_q[13:7];
  assign HEX2 = hex_q[20:14];
  assign HEX3 = hex_q[27:21];
  assign HEX4 = hex_q[34:28];
  assign HEX5 = hex_q[41:35];

endmodule

// File: tb/tb_hex_bcd_display.sv
// Scoreboard bench for hex_bcd_display: main instance (load-driven) plus an AUTO_LOAD=1 instance.
module tb_hex_bcd_display;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic [19:0] value = '0;
  logic        load = 1'b0;
  logic        busy, done;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  logic        rst_a = 1'b1;
  logic [19:0] value_a = 20'd1000;
  logic        load_a = 1'b0;
  logic        busy_a, done_a;
  logic [6:0]  HA0, HA1, HA2, HA3, HA4, HA5;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int auto_cnt = 0;
  int last_a = -1;
  logic done_prev = 1'b0;

  typedef struct {
    logic [41:0] hex;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  hex_bcd_display #(.AUTO_LOAD(1'b0)) dut (
    .CLOCK_50(clk), .Reset(Reset), .value(value), .load(load),
    .busy(busy), .done(done),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
  );

  hex_bcd_display #(.AUTO_LOAD(1'b1)) dut_auto (
    .CLOCK_50(clk), .Reset(rst_a), .value(value_a), .load(load_a),
    .busy(busy_a), .done(done_a),
    .HEX0(HA0), .HEX1(HA1), .HEX2(HA2), .HEX3(HA3), .HEX4(HA4), .HEX5(HA5)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  // Reference conversion by repeated division, independent of the shift-add method.
  function automatic logic [41:0] exp_hex(input int v);
    logic [41:0] r;
    int dg[6];
    int t;
`ifdef LEADING_ZERO_BLANK_EN
    bit lead;
    lead = 1'b1;
`endif
    if (v > 999999) return {6{7'b0111111}};
    t = v;
    for (int i = 0; i < 6; i++) begin
      dg[i] = t % 10;
      t = t / 10;
    end
    r = '1;
    for (int i = 5; i >= 0; i--) begin
      r[7*i +: 7] = seg_of(dg[i]);
`ifdef LEADING_ZERO_BLANK_EN
      if (lead && dg[i] == 0 && i > 0) r[7*i +: 7] = 7'b1111111;
      else lead = 1'b0;
`endif
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Main monitor: every done pulse pops one expectation.
  always @(negedge clk) begin
    if (!Reset && done === 1'b1) begin
      check("done_width", {63'd0, done_prev}, 64'd0);
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no pending conversion (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("hex", {22'd0, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {22'd0, e.hex});
        check("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    done_prev = done;
  end

  // AUTO_LOAD monitor: value_a at edge e is 1000+e-1, capture edge is done edge - 21.
  always @(negedge clk) begin
    value_a = 20'(1000 + cyc);
    if (!rst_a && done_a === 1'b1) begin
      check("auto_hex", {22'd0, HA5, HA4, HA3, HA2, HA1, HA0}, {22'd0, exp_hex(1000 + cyc - 22)});
      if (last_a >= 0) check("auto_period", 64'(cyc - last_a), 64'd22);
      last_a = cyc;
      auto_cnt++;
    end
  end

  task automatic convert(input logic [19:0] v, input bit chk);
    @(negedge clk);
    value = v;
    load = 1'b1;
    sb.push_back('{exp_hex(int'(v)), cyc + 22});
    for (int i = 0; i <= 21; i++) begin
      @(negedge clk);
      load = 1'b0;
      if (chk) begin
        check("busy", {63'd0, busy}, {63'd0, (i < 21)});
        check("done", {63'd0, done}, {63'd0, (i == 21)});
      end
    end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    Reset = 1'b0;
    rst_a = 1'b0;
    @(negedge clk);
    check("rst_hex", {22'd0, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {22'd0, {6{7'b1111111}}});
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);

    convert(20'd123456, 1'b1);
    check("h123456", {22'd0, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0},
          {22'd0, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010});

    convert(20'd42, 1'b0);
    check("h42_lo", {50'd0, HEX1, HEX0}, {50'd0, 7'b0011001, 7'b0100100});
`ifdef LEADING_ZERO_BLANK_EN
    check("h42_hi", {36'd0, HEX5, HEX4, HEX3, HEX2}, {36'd0, {4{7'b1111111}}});
`else
    check("h42_hi", {36'd0, HEX5, HEX4, HEX3, HEX2}, {36'd0, {4{7'b1000000}}});
`endif

    convert(20'd999999, 1'b0);
    check("h999999", {22'd0, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {22'd0, {6{7'b0010000}}});
    convert(20'd1000000, 1'b0);
    check("h1000000", {22'd0, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {22'd0, {6{7'b0111111}}});
    convert(20'd0, 1'b0);
    convert(20'd1048575, 1'b0);
    convert(20'd100205, 1'b0);
    convert(20'd7, 1'b0);

    // Back-to-back: load held through done, second capture one cycle after done.
    @(negedge clk);
    n = cyc;
    value = 20'd314159;
    load = 1'b1;
    sb.push_back('{exp_hex(314159), n + 22});
    repeat (22) @(negedge clk);
    value = 20'd271828;
    sb.push_back('{exp_hex(271828), n + 44});
    @(negedge clk);
    load = 1'b0;
    repeat (21) @(negedge clk);

    // Load held high, value changed mid-conversion, then reset aborts the follow-on conversion.
    @(negedge clk);
    n = cyc;
    value = 20'd55555;
    load = 1'b1;
    sb.push_back('{exp_hex(55555), n + 22});
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (i == 5) value = 20'd888888;
    end
    Reset = 1'b1;
    load = 1'b0;
    #1;
    check("abort_hex", {22'd0, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {22'd0, {6{7'b1111111}}});
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    Reset = 1'b0;
    repeat (40) @(negedge clk);
    check("idle_busy", {63'd0, busy}, 64'd0);
    check("idle_hex", {22'd0, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {22'd0, {6{7'b1111111}}});

    check("sb_empty", 64'(sb.size()), 64'd0);
    check("auto_seen", 64'(auto_cnt >= 5), 64'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
